// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - 44-bit MSB-first single-wire serial transmitter; SER_TX_PARITY_EN appends an even-parity bit
module ser_tx #(
    parameter int   WIDTH    = 44,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             aout,
    output logic             aframe,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_DONE} state_t;
    logic par;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t           state;
    // Holds only the bits not yet on the wire; the MSB goes out at capture.
    logic [WIDTH-2:0] shreg;
    logic [CW-1:0]    cnt;

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            aout   <= IDLE_BIT;
            aframe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shreg  <= din[WIDTH-2:0];
                        cnt    <= CW'(WIDTH - 1);
                        aout   <= din[WIDTH-1];
                        aframe <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
`ifdef SER_TX_PARITY_EN
                        par    <= ^din;
`endif
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
`ifdef SER_TX_PARITY_EN
                        aout   <= par;
                        state  <= S_PAR;
`else
                        aout   <= IDLE_BIT;
                        aframe <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
`endif
                    end else begin
                        aout  <= shreg[WIDTH-2];
                        shreg <= shreg << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
`ifdef SER_TX_PARITY_EN
                S_PAR: begin
                    aout   <= IDLE_BIT;
                    aframe <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
`endif
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
